// File: rtl/ysyx_22041071_axi_rd_master_pkg.sv
// Shared encodings for the AXI4 read master: FSM states, burst/response codes, field widths.
package ysyx_22041071_axi_rd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_RESP_W = 2;
  localparam int CPU_SIZE_W = 2;
  localparam int AXI_SIZE_W = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // A beat is malformed when RLAST disagrees with the beat count (early or
  // missing last) or when it carries a foreign ID.
  function automatic logic beat_err(input logic rlast, input logic last_cnt,
                                    input logic id_bad);
    return (rlast ^ last_cnt) | id_bad;
  endfunction

endpackage

// File: rtl/ysyx_22041071_rd_watchdog.sv
// Stall watchdog for the AXI read master: counts idle cycles while a transaction is open.
// Only built when AXI_RD_TIMEOUT_EN is defined.
`ifdef AXI_RD_TIMEOUT_EN
module ysyx_22041071_rd_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Fires on the LIMIT-th consecutive cycle without a handshake.
  assign expired = en && !clr && (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (!en || clr || expired) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/ysyx_22041071_axi_rd_master.sv
// Single-outstanding AXI4 INCR read master behind the IF/MEM arbiter; one cpu_r pulse per beat.
// Optional stall watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module ysyx_22041071_axi_rd_master
  import ysyx_22041071_axi_rd_master_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4,
  parameter int AXI_ID      = 0,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // Valid/ready: a transfer happens on any rising edge where both are high;
  // a valid source holds its payload stable until that edge.
  input  logic                  cpu_ar_valid,
  input  logic [ADDR_W-1:0]     cpu_ar_addr,
  input  logic [AXI_LEN_W-1:0]  cpu_ar_len,
  input  logic [CPU_SIZE_W-1:0] cpu_ar_size,
  output logic                  cpu_ar_ready,
  output logic                  cpu_r_valid,
  output logic [DATA_W-1:0]     cpu_r_data,
  output logic [ADDR_W-1:0]     cpu_r_addr,
  output logic [AXI_RESP_W-1:0] cpu_r_resp,
  output logic                  axi_ar_valid,
  input  logic                  axi_ar_ready,
  output logic [ADDR_W-1:0]     axi_ar_addr,
  output logic [ID_W-1:0]       axi_ar_id,
  output logic [AXI_LEN_W-1:0]  axi_ar_len,
  output logic [AXI_SIZE_W-1:0] axi_ar_size,
  output logic [1:0]            axi_ar_burst,
  input  logic                  axi_r_valid,
  output logic                  axi_r_ready,
  input  logic [DATA_W-1:0]     axi_r_data,
  input  logic [AXI_RESP_W-1:0] axi_r_resp,
  input  logic                  axi_r_last,
  input  logic [ID_W-1:0]       axi_r_id,
  output logic [1:0]            dbg_state
);

  rd_state_e                state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [AXI_LEN_W-1:0]     len_q, len_d;
  logic [CPU_SIZE_W-1:0]    size_q, size_d;
  logic [AXI_LEN_W-1:0]     cnt_q, cnt_d;
  logic                     r_valid_q, r_valid_d;
  logic [DATA_W-1:0]        r_data_q, r_data_d;
  logic [ADDR_W-1:0]        r_addr_q, r_addr_d;
  logic [AXI_RESP_W-1:0]    r_resp_q, r_resp_d;

  logic              ar_fire;
  logic              r_fire;
  logic              last_cnt;
  logic              id_bad;
  logic [ADDR_W-1:0] beat_addr;

  assign ar_fire   = (state_q == ST_ADDR) && axi_ar_ready;
  assign r_fire    = (state_q == ST_DATA) && axi_r_valid;
  assign last_cnt  = (cnt_q == len_q);
  assign id_bad    = (axi_r_id != ID_W'(AXI_ID));
  assign beat_addr = addr_q + (ADDR_W'(cnt_q) << size_q);

`ifdef AXI_RD_TIMEOUT_EN
  logic wd_expired;

  ysyx_22041071_rd_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != ST_IDLE),
    .clr     (ar_fire || r_fire),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    r_addr_d  = r_addr_q;
    r_resp_d  = r_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_ar_valid && cpu_ar_ready) begin
          addr_d  = cpu_ar_addr;
          len_d   = cpu_ar_len;
          size_d  = cpu_ar_size;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_fire) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_fire) begin
          r_valid_d = 1'b1;
          r_data_d  = axi_r_data;
          r_addr_d  = beat_addr;
          r_resp_d  = beat_err(axi_r_last, last_cnt, id_bad) ? AXI_RESP_SLVERR : axi_r_resp;
          cnt_d     = cnt_q + 1'b1;
          // Whichever of RLAST or the beat count arrives first ends the burst.
          if (axi_r_last || last_cnt) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AXI_RD_TIMEOUT_EN
    if (wd_expired) begin
      r_valid_d = 1'b1;
      r_data_d  = '0;
      r_addr_d  = beat_addr;
      r_resp_d  = AXI_RESP_DECERR;
      state_d   = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_addr_q  <= '0;
      r_resp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_addr_q  <= r_addr_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Holding ready low during the final pulse keeps a new request out of that cycle.
  assign cpu_ar_ready = (state_q == ST_IDLE) && !r_valid_q;

  assign cpu_r_valid  = r_valid_q;
  assign cpu_r_data   = r_data_q;
  assign cpu_r_addr   = r_addr_q;
  assign cpu_r_resp   = r_resp_q;

  assign axi_ar_valid = (state_q == ST_ADDR);
  assign axi_ar_addr  = addr_q;
  assign axi_ar_id    = ID_W'(AXI_ID);
  assign axi_ar_len   = len_q;
  assign axi_ar_size  = {1'b0, size_q};
  assign axi_ar_burst = AXI_BURST_INCR;
  assign axi_r_ready  = (state_q == ST_DATA);

  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_master.sv
// Directed bench for the AXI4 read master: bench acts as arbiter and AXI slave,
// a negedge monitor scores every cpu_r pulse against expected queues.
module tb_ysyx_22041071_axi_rd_master;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic              clk;
  logic              rst;
  logic              cpu_ar_valid;
  logic [ADDR_W-1:0] cpu_ar_addr;
  logic [7:0]        cpu_ar_len;
  logic [1:0]        cpu_ar_size;
  logic              cpu_ar_ready;
  logic              cpu_r_valid;
  logic [DATA_W-1:0] cpu_r_data;
  logic [ADDR_W-1:0] cpu_r_addr;
  logic [1:0]        cpu_r_resp;
  logic              axi_ar_valid;
  logic              axi_ar_ready;
  logic [ADDR_W-1:0] axi_ar_addr;
  logic [ID_W-1:0]   axi_ar_id;
  logic [7:0]        axi_ar_len;
  logic [2:0]        axi_ar_size;
  logic [1:0]        axi_ar_burst;
  logic              axi_r_valid;
  logic              axi_r_ready;
  logic [DATA_W-1:0] axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;
  logic [ID_W-1:0]   axi_r_id;
  logic [1:0]        dbg_state;

  ysyx_22041071_axi_rd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_ar_valid(cpu_ar_valid), .cpu_ar_addr(cpu_ar_addr), .cpu_ar_len(cpu_ar_len),
    .cpu_ar_size(cpu_ar_size), .cpu_ar_ready(cpu_ar_ready),
    .cpu_r_valid(cpu_r_valid), .cpu_r_data(cpu_r_data), .cpu_r_addr(cpu_r_addr),
    .cpu_r_resp(cpu_r_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  logic [DATA_W-1:0] exp_data_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [1:0]        exp_resp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cpu_r_valid) begin
      pulse_cnt++;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        check("r_data", cpu_r_data, exp_data_q.pop_front());
        check("r_addr", cpu_r_addr, exp_addr_q.pop_front());
        check("r_resp", {62'd0, cpu_r_resp}, {62'd0, exp_resp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input logic [63:0] a, input logic [7:0] l, input logic [1:0] s);
    cpu_ar_valid = 1'b1;
    cpu_ar_addr  = a;
    cpu_ar_len   = l;
    cpu_ar_size  = s;
    check("req_ready", {63'd0, cpu_ar_ready}, 64'd1);
    @(negedge clk);
    cpu_ar_valid = 1'b0;
  endtask

  task automatic ar_fields(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    check("ar_addr", axi_ar_addr, a);
    check("ar_len", {56'd0, axi_ar_len}, {56'd0, l});
    check("ar_size", {61'd0, axi_ar_size}, {61'd0, s});
    check("ar_burst", {62'd0, axi_ar_burst}, 64'd1);
    check("ar_id", {60'd0, axi_ar_id}, 64'd0);
  endtask

  task automatic ar_accept(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                           input int delay);
    for (int i = 0; i < 50 && !axi_ar_valid; i++) @(negedge clk);
    check("ar_valid_seen", {63'd0, axi_ar_valid}, 64'd1);
    for (int i = 0; i < delay; i++) begin
      ar_fields(a, l, s);
      @(negedge clk);
    end
    check("ar_valid_held", {63'd0, axi_ar_valid}, 64'd1);
    ar_fields(a, l, s);
    axi_ar_ready = 1'b1;
    @(negedge clk);
    axi_ar_ready = 1'b0;
  endtask

  // Returns at the negedge where the resulting cpu_r pulse is visible.
  task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic last,
                        input logic [3:0] id, input int gap,
                        input logic [63:0] exp_addr, input logic [1:0] exp_resp);
    repeat (gap) @(negedge clk);
    check("r_ready", {63'd0, axi_r_ready}, 64'd1);
    axi_r_valid = 1'b1;
    axi_r_data  = d;
    axi_r_resp  = resp;
    axi_r_last  = last;
    axi_r_id    = id;
    exp_data_q.push_back(d);
    exp_addr_q.push_back(exp_addr);
    exp_resp_q.push_back(exp_resp);
    @(negedge clk);
    axi_r_valid = 1'b0;
    axi_r_last  = 1'b0;
    check("r_pulse", {63'd0, cpu_r_valid}, 64'd1);
  endtask

  task automatic ready_after_pulse();
    check("ready_low_on_pulse", {63'd0, cpu_ar_ready}, 64'd0);
    @(negedge clk);
    check("ready_back", {63'd0, cpu_ar_ready}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int pulses_before;

  initial begin
    rst = 1'b1;
    cpu_ar_valid = 1'b0; cpu_ar_addr = '0; cpu_ar_len = '0; cpu_ar_size = '0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = '0; axi_r_resp = '0;
    axi_r_last = 1'b0; axi_r_id = '0;
    repeat (3) @(negedge clk);

    check("rst_ar_ready", {63'd0, cpu_ar_ready}, 64'd1);
    check("rst_r_valid", {63'd0, cpu_r_valid}, 64'd0);
    check("rst_axi_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
    check("rst_axi_r_ready", {63'd0, axi_r_ready}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat
    issue_req(64'h8000_0000, 8'd0, 2'd3);
    ar_accept(64'h8000_0000, 8'd0, 3'd3, 0);
    r_beat(64'hDEAD_BEEF, 2'b00, 1'b1, 4'd0, 0, 64'h8000_0000, 2'b00);
    ready_after_pulse();

    // Four-beat burst, AR delay 2, R gaps, one EXOKAY passthrough
    issue_req(64'h8000_0100, 8'd3, 2'd3);
    ar_accept(64'h8000_0100, 8'd3, 3'd3, 2);
    r_beat(64'h1111, 2'b00, 1'b0, 4'd0, 1, 64'h8000_0100, 2'b00);
    r_beat(64'h2222, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0108, 2'b00);
    r_beat(64'h3333, 2'b01, 1'b0, 4'd0, 2, 64'h8000_0110, 2'b01);
    r_beat(64'h4444, 2'b00, 1'b1, 4'd0, 1, 64'h8000_0118, 2'b00);
    ready_after_pulse();

    // Early rlast on beat 1 of len=3
    issue_req(64'h8000_0200, 8'd3, 2'd3);
    ar_accept(64'h8000_0200, 8'd3, 3'd3, 0);
    r_beat(64'hA0, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0200, 2'b00);
    r_beat(64'hA1, 2'b00, 1'b1, 4'd0, 0, 64'h8000_0208, 2'b10);
    check("early_last_idle", {62'd0, dbg_state}, 64'd0);
    ready_after_pulse();

    // Missing last: len=0 beat without rlast still ends the burst, flagged
    issue_req(64'h8000_0300, 8'd0, 2'd2);
    ar_accept(64'h8000_0300, 8'd0, 3'd2, 1);
    r_beat(64'hB0, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0300, 2'b10);
    check("missing_last_idle", {62'd0, dbg_state}, 64'd0);
    ready_after_pulse();

    // Foreign RID
    issue_req(64'h8000_0400, 8'd0, 2'd3);
    ar_accept(64'h8000_0400, 8'd0, 3'd3, 0);
    r_beat(64'hC0, 2'b00, 1'b1, 4'd5, 0, 64'h8000_0400, 2'b10);
    ready_after_pulse();

    // Async reset mid-DATA after beat 1 (size=2 -> 4-byte stride)
    issue_req(64'h8000_0500, 8'd3, 2'd2);
    ar_accept(64'h8000_0500, 8'd3, 3'd2, 0);
    r_beat(64'hD0, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0500, 2'b00);
    r_beat(64'hD1, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0504, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("arst_r_valid", {63'd0, cpu_r_valid}, 64'd0);
    check("arst_r_addr", cpu_r_addr, 64'd0);
    check("arst_ar_ready", {63'd0, cpu_ar_ready}, 64'd1);
    check("arst_r_ready", {63'd0, axi_r_ready}, 64'd0);
    check("arst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses_before = pulse_cnt;
    axi_r_valid = 1'b1; axi_r_data = 64'hD2; axi_r_last = 1'b0;
    @(negedge clk);
    axi_r_data = 64'hD3; axi_r_last = 1'b1;
    @(negedge clk);
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
    @(negedge clk);
    check("arst_no_pulse", 64'(pulse_cnt - pulses_before), 64'd0);
    check("arst_ar_valid", {63'd0, axi_ar_valid}, 64'd0);

    // Back-to-back with cpu_ar_valid held high
    cpu_ar_valid = 1'b1; cpu_ar_addr = 64'h8000_0600; cpu_ar_len = 8'd1; cpu_ar_size = 2'd3;
    check("b2b_ready", {63'd0, cpu_ar_ready}, 64'd1);
    @(negedge clk);
    cpu_ar_addr = 64'h8000_0700;
    check("b2b_busy", {63'd0, cpu_ar_ready}, 64'd0);
    ar_accept(64'h8000_0600, 8'd1, 3'd3, 0);
    check("b2b_no_ar_data", {63'd0, axi_ar_valid}, 64'd0);
    r_beat(64'hE0, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0600, 2'b00);
    r_beat(64'hE1, 2'b00, 1'b1, 4'd0, 0, 64'h8000_0608, 2'b00);
    check("b2b_no_ar_pulse", {63'd0, axi_ar_valid}, 64'd0);
    check("b2b_ready_pulse", {63'd0, cpu_ar_ready}, 64'd0);
    @(negedge clk);
    check("b2b_ready_idle", {63'd0, cpu_ar_ready}, 64'd1);
    check("b2b_no_ar_idle", {63'd0, axi_ar_valid}, 64'd0);
    @(negedge clk);
    cpu_ar_valid = 1'b0;
    ar_accept(64'h8000_0700, 8'd1, 3'd3, 0);
    r_beat(64'hF0, 2'b00, 1'b0, 4'd0, 0, 64'h8000_0700, 2'b00);
    r_beat(64'hF1, 2'b00, 1'b1, 4'd0, 0, 64'h8000_0708, 2'b00);
    ready_after_pulse();

`ifdef AXI_RD_TIMEOUT_EN
    // Slave never returns data: DECERR pulse 16 cycles after the AR handshake
    begin
      int cyc;
      issue_req(64'h8000_0800, 8'd0, 2'd3);
      ar_accept(64'h8000_0800, 8'd0, 3'd3, 0);
      exp_data_q.push_back(64'd0);
      exp_addr_q.push_back(64'h8000_0800);
      exp_resp_q.push_back(2'b11);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (cpu_r_valid) begin
          cyc = i;
          break;
        end
      end
      check("wd_latency", 64'(cyc), 64'd16);
      ready_after_pulse();
    end
`endif

    repeat (2) @(negedge clk);
    check("exp_left", 64'(exp_addr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
